// File: rtl/load_store_unit.sv
// Load/store unit: one byte/half/word access per request over valid/ready data-bus channels.
// Handles strobe generation, store lane replication, load extraction/extension and misalignment aborts.
module load_store_unit #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      ls_start_i,
    input  logic                      ls_store_i,
    input  logic [1:0]                ls_size_i,
    input  logic                      ls_unsigned_i,
    input  logic [ADDR_WIDTH-1:0]     ls_addr_i,
    input  logic [DATA_WIDTH-1:0]     ls_wdata_i,
    output logic                      ls_busy_o,
    output logic                      ls_done_o,
    output logic                      ls_misaligned_o,
    output logic [DATA_WIDTH-1:0]     ls_rdata_o,
    output logic                      dr_addr_valid_o,
    input  logic                      dr_addr_ready_i,
    output logic [ADDR_WIDTH-1:0]     dr_addr_o,
    input  logic                      dr_data_valid_i,
    output logic                      dr_data_ready_o,
    input  logic [DATA_WIDTH-1:0]     dr_data_i,
    output logic                      dw_valid_o,
    input  logic                      dw_ready_i,
    output logic [ADDR_WIDTH-1:0]     dw_addr_o,
    output logic [DATA_WIDTH-1:0]     dw_data_o,
    output logic [DATA_WIDTH/8-1:0]   dw_strobe_o,
    input  logic                      dw_resp_valid_i,
    output logic                      dw_resp_ready_o
);
    localparam int unsigned STRB_W   = DATA_WIDTH / 8;
    localparam int unsigned OFF_W    = $clog2(STRB_W);
    localparam int unsigned HALF_REP = DATA_WIDTH / 16;

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, ERR
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [OFF_W-1:0]      off_q, off_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     strobe_q, strobe_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  done_q, done_d;
    logic                  mis_q, mis_d;

    logic                  misaligned;
    logic [DATA_WIDTH-1:0] st_data;
    logic [STRB_W-1:0]     st_strobe;
    logic [DATA_WIDTH-1:0] ld_shifted;
    logic [DATA_WIDTH-1:0] ld_data;

    // Request decode: alignment check and store lane replication from the live inputs.
    always_comb begin
        misaligned = 1'b0;
        st_data    = ls_wdata_i;
        st_strobe  = '1;
        case (ls_size_i)
            2'd0: begin
                st_data   = {STRB_W{ls_wdata_i[7:0]}};
                st_strobe = STRB_W'(1) << ls_addr_i[OFF_W-1:0];
            end
            2'd1: begin
                misaligned = ls_addr_i[0];
                st_data    = {HALF_REP{ls_wdata_i[15:0]}};
                st_strobe  = STRB_W'(3) << ls_addr_i[OFF_W-1:0];
            end
            2'd2: misaligned = |ls_addr_i[OFF_W-1:0];
            default: misaligned = 1'b1;
        endcase
    end

    // Load lane extraction with sign/zero extension.
    always_comb begin
        ld_shifted = dr_data_i >> {off_q, 3'b000};
        case (size_q)
            2'd0:    ld_data = {{(DATA_WIDTH-8){~uns_q & ld_shifted[7]}}, ld_shifted[7:0]};
            2'd1:    ld_data = {{(DATA_WIDTH-16){~uns_q & ld_shifted[15]}}, ld_shifted[15:0]};
            default: ld_data = ld_shifted;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            off_q    <= '0;
            size_q   <= '0;
            uns_q    <= 1'b0;
            wdata_q  <= '0;
            strobe_q <= '0;
            rdata_q  <= '0;
            done_q   <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            off_q    <= off_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            wdata_q  <= wdata_d;
            strobe_q <= strobe_d;
            rdata_q  <= rdata_d;
            done_q   <= done_d;
            mis_q    <= mis_d;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        off_d    = off_q;
        size_d   = size_q;
        uns_d    = uns_q;
        wdata_d  = wdata_q;
        strobe_d = strobe_q;
        rdata_d  = rdata_q;
        done_d   = 1'b0;
        mis_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (ls_start_i) begin
                    addr_d   = {ls_addr_i[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
                    off_d    = ls_addr_i[OFF_W-1:0];
                    size_d   = ls_size_i;
                    uns_d    = ls_unsigned_i;
                    wdata_d  = st_data;
                    strobe_d = st_strobe;
                    if (misaligned)      state_d = ERR;
                    else if (ls_store_i) state_d = WR_REQ;
                    else                 state_d = RD_REQ;
                end
            end
            RD_REQ:  if (dr_addr_ready_i) state_d = RD_WAIT;
            RD_WAIT: begin
                if (dr_data_valid_i) begin
                    rdata_d = ld_data;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            WR_REQ:  if (dw_ready_i) state_d = WR_WAIT;
            WR_WAIT: begin
                if (dw_resp_valid_i) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            ERR: begin
                done_d  = 1'b1;
                mis_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ls_busy_o       = (state_q != IDLE);
    assign ls_done_o       = done_q;
    assign ls_misaligned_o = mis_q;
    assign ls_rdata_o      = rdata_q;
    assign dr_addr_valid_o = (state_q == RD_REQ);
    assign dr_addr_o       = addr_q;
    assign dr_data_ready_o = (state_q == RD_WAIT);
    assign dw_valid_o      = (state_q == WR_REQ);
    assign dw_addr_o       = addr_q;
    assign dw_data_o       = wdata_q;
    assign dw_strobe_o     = strobe_q;
    assign dw_resp_ready_o = (state_q == WR_WAIT);

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected bus beats and completions are queued at issue
// and compared by a monitor when the DUT produces them.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        ls_start, ls_store, ls_unsigned;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr, ls_wdata;
    logic        ls_busy, ls_done, ls_misaligned;
    logic [31:0] ls_rdata;
    logic        dr_addr_valid, dr_addr_ready, dr_data_valid, dr_data_ready;
    logic [31:0] dr_addr, dr_data;
    logic        dw_valid, dw_ready, dw_resp_valid, dw_resp_ready;
    logic [31:0] dw_addr, dw_data;
    logic [3:0]  dw_strobe;

    load_store_unit dut (
        .clk_i(clk), .rst_i(rst),
        .ls_start_i(ls_start), .ls_store_i(ls_store), .ls_size_i(ls_size),
        .ls_unsigned_i(ls_unsigned), .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata),
        .ls_busy_o(ls_busy), .ls_done_o(ls_done), .ls_misaligned_o(ls_misaligned),
        .ls_rdata_o(ls_rdata),
        .dr_addr_valid_o(dr_addr_valid), .dr_addr_ready_i(dr_addr_ready), .dr_addr_o(dr_addr),
        .dr_data_valid_i(dr_data_valid), .dr_data_ready_o(dr_data_ready), .dr_data_i(dr_data),
        .dw_valid_o(dw_valid), .dw_ready_i(dw_ready), .dw_addr_o(dw_addr),
        .dw_data_o(dw_data), .dw_strobe_o(dw_strobe),
        .dw_resp_valid_i(dw_resp_valid), .dw_resp_ready_o(dw_resp_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_load;
        logic        mis;
        logic [31:0] rdata;
        logic [31:0] cyc;
    } done_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_exp_t;

    done_exp_t   dq[$];
    logic [31:0] raq[$];
    wr_exp_t     wq[$];

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] cyc      = '0;
    logic [31:0] model_rdata = '0;
    int          any_req  = 0;

    int          ar_delay = 0, dv_delay = 0, dw_delay = 0, rs_delay = 0;
    int          ar_cnt = 0, dv_cnt = 0, dw_cnt = 0, rs_cnt = 0;
    logic        dv_force = 1'b0;
    logic [31:0] rd_value = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Bus responder: each ready/valid goes high after a programmable number of waiting cycles.
    always @(posedge clk) begin
        #1;
        if (dr_addr_valid) begin dr_addr_ready = (ar_cnt >= ar_delay); ar_cnt++; end
        else begin dr_addr_ready = 1'b0; ar_cnt = 0; end
        if (dr_data_ready) begin dr_data_valid = (dv_cnt >= dv_delay) || dv_force; dv_cnt++; end
        else begin dr_data_valid = dv_force; dv_cnt = 0; end
        dr_data = rd_value;
        if (dw_valid) begin dw_ready = (dw_cnt >= dw_delay); dw_cnt++; end
        else begin dw_ready = 1'b0; dw_cnt = 0; end
        if (dw_resp_ready) begin dw_resp_valid = (rs_cnt >= rs_delay); rs_cnt++; end
        else begin dw_resp_valid = 1'b0; rs_cnt = 0; end
    end

    // Monitor: compares every request beat and completion against the scoreboard.
    always @(negedge clk) begin
        if (dr_addr_valid || dw_valid) any_req++;
        if (dr_addr_valid) begin
            if (raq.size() == 0) check("unexpected_rd_req", 32'd1, 32'd0);
            else begin
                check("dr_addr", dr_addr, raq[0]);
                if (dr_addr_ready) void'(raq.pop_front());
            end
        end
        if (dw_valid) begin
            if (wq.size() == 0) check("unexpected_wr_req", 32'd1, 32'd0);
            else begin
                check("dw_addr", dw_addr, wq[0].addr);
                check("dw_data", dw_data, wq[0].data);
                check("dw_strobe", 32'(dw_strobe), 32'(wq[0].strb));
                if (dw_ready) void'(wq.pop_front());
            end
        end
        if (ls_done) begin
            if (dq.size() == 0) check("unexpected_done", 32'd1, 32'd0);
            else begin
                done_exp_t e;
                e = dq.pop_front();
                if (e.is_load && !e.mis) model_rdata = e.rdata;
                check("done_cycle", cyc, e.cyc);
                check("misaligned", 32'(ls_misaligned), 32'(e.mis));
                check("rdata", ls_rdata, model_rdata);
                check("busy_at_done", 32'(ls_busy), 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic st, input logic [1:0] sz, input logic un,
                         input logic [31:0] a, input logic [31:0] wd, input logic mis,
                         input logic [31:0] exp_r, input logic [31:0] exp_wd,
                         input logic [3:0] exp_strb);
        done_exp_t e;
        wr_exp_t   w;
        int        lat;
        lat = mis ? 2 : (st ? 3 + dw_delay + rs_delay : 3 + ar_delay + dv_delay);
        e.is_load = ~st;
        e.mis     = mis;
        e.rdata   = exp_r;
        e.cyc     = cyc + 32'(lat);
        dq.push_back(e);
        if (!mis && !st) raq.push_back(a & 32'hFFFF_FFFC);
        if (!mis && st) begin
            w.addr = a & 32'hFFFF_FFFC;
            w.data = exp_wd;
            w.strb = exp_strb;
            wq.push_back(w);
        end
        ls_start = 1'b1; ls_store = st; ls_size = sz; ls_unsigned = un;
        ls_addr = a; ls_wdata = wd;
        step();
        ls_start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60; i++) begin
            if (dq.size() == 0) break;
            @(negedge clk);
        end
        check("timeout_pending", 32'(dq.size()), 32'd0);
        step();
    endtask

    initial begin
        int req_before;
        rst = 1'b1; ls_start = 1'b0; ls_store = 1'b0; ls_size = 2'd0; ls_unsigned = 1'b0;
        ls_addr = '0; ls_wdata = '0;
        dr_addr_ready = 1'b0; dr_data_valid = 1'b0; dr_data = '0;
        dw_ready = 1'b0; dw_resp_valid = 1'b0;
        repeat (2) step();
        @(negedge clk);
        check("rst_busy", 32'(ls_busy), 32'd0);
        check("rst_done", 32'(ls_done), 32'd0);
        check("rst_mis", 32'(ls_misaligned), 32'd0);
        check("rst_rdata", ls_rdata, 32'd0);
        check("rst_dr_valid", 32'(dr_addr_valid), 32'd0);
        check("rst_dr_addr", dr_addr, 32'd0);
        check("rst_dr_ready", 32'(dr_data_ready), 32'd0);
        check("rst_dw_valid", 32'(dw_valid), 32'd0);
        check("rst_dw_addr", dw_addr, 32'd0);
        check("rst_dw_data", dw_data, 32'd0);
        check("rst_dw_strobe", 32'(dw_strobe), 32'd0);
        check("rst_resp_ready", 32'(dw_resp_ready), 32'd0);
        step();
        rst = 1'b0;
        step();

        // Aligned word load, zero wait.
        rd_value = 32'hDEAD_BEEF;
        issue(1'b0, 2'd2, 1'b0, 32'h100, '0, 1'b0, 32'hDEAD_BEEF, '0, '0);
        wait_done();

        // Byte loads at the top lane, signed and unsigned.
        rd_value = 32'h8000_0000;
        issue(1'b0, 2'd0, 1'b0, 32'h103, '0, 1'b0, 32'hFFFF_FF80, '0, '0);
        wait_done();
        issue(1'b0, 2'd0, 1'b1, 32'h103, '0, 1'b0, 32'h0000_0080, '0, '0);
        wait_done();

        // Signed half load from upper lane.
        rd_value = 32'h8001_1234;
        issue(1'b0, 2'd1, 1'b0, 32'h002, '0, 1'b0, 32'hFFFF_8001, '0, '0);
        wait_done();
        issue(1'b0, 2'd1, 1'b1, 32'h040, '0, 1'b0, 32'h0000_1234, '0, '0);
        wait_done();

        // Stores: half at 0x2, byte at 0x1, word with write-side waits.
        issue(1'b1, 2'd1, 1'b0, 32'h002, 32'h1234_ABCD, 1'b0, '0, 32'hABCD_ABCD, 4'b1100);
        wait_done();
        issue(1'b1, 2'd0, 1'b0, 32'h001, 32'h0000_0055, 1'b0, '0, 32'h5555_5555, 4'b0010);
        wait_done();
        dw_delay = 2; rs_delay = 1;
        issue(1'b1, 2'd2, 1'b0, 32'h0C4, 32'h0BAD_F00D, 1'b0, '0, 32'h0BAD_F00D, 4'b1111);
        wait_done();
        dw_delay = 0; rs_delay = 0;

        // Misaligned accesses: no bus traffic, rdata held.
        req_before = any_req;
        issue(1'b0, 2'd2, 1'b0, 32'h005, '0, 1'b1, '0, '0, '0);
        wait_done();
        issue(1'b1, 2'd1, 1'b0, 32'h011, 32'hFFFF_FFFF, 1'b1, '0, '0, '0);
        wait_done();
        issue(1'b0, 2'd3, 1'b0, 32'h020, '0, 1'b1, '0, '0, '0);
        wait_done();
        check("mis_no_bus", 32'(any_req), 32'(req_before));

        // Backpressure with ignored start pulses while busy.
        ar_delay = 3; dv_delay = 2; rd_value = 32'h1122_3344;
        issue(1'b0, 2'd2, 1'b0, 32'h200, '0, 1'b0, 32'h1122_3344, '0, '0);
        for (int i = 0; i < 6; i++) begin
            ls_start = (i % 2 == 0); ls_store = 1'b1; ls_size = 2'd0;
            ls_addr = 32'h300 + 32'(i); ls_wdata = 32'hFF;
            step();
        end
        ls_start = 1'b0;
        wait_done();
        ar_delay = 0; dv_delay = 0;

        // Back-to-back: second start in the cycle ls_done is high.
        rd_value = 32'hA5A5_0F0F;
        issue(1'b0, 2'd2, 1'b0, 32'h400, '0, 1'b0, 32'hA5A5_0F0F, '0, '0);
        step();
        step();
        check("b2b_done_high", 32'(ls_done), 32'd1);
        issue(1'b1, 2'd0, 1'b0, 32'h402, 32'h0000_00C3, 1'b0, '0, 32'hC3C3_C3C3, 4'b0100);
        wait_done();

        // Reset while waiting for read data; late data must be ignored.
        dv_delay = 5; rd_value = 32'h7777_7777;
        issue(1'b0, 2'd2, 1'b0, 32'h080, '0, 1'b0, 32'h7777_7777, '0, '0);
        step();
        step();
        check("rst_in_rd_wait", 32'(dr_data_ready), 32'd1);
        rst = 1'b1;
        dq.delete();
        model_rdata = '0;
        step();
        rst = 1'b0;
        dv_force = 1'b1;
        @(negedge clk);
        check("post_rst_busy", 32'(ls_busy), 32'd0);
        check("post_rst_ready", 32'(dr_data_ready), 32'd0);
        check("post_rst_done", 32'(ls_done), 32'd0);
        step();
        dv_force = 1'b0;
        dv_delay = 0;
        repeat (3) step();
        check("late_data_ignored", 32'(ls_busy), 32'd0);
        check("post_rst_rdata", ls_rdata, 32'd0);
        issue(1'b1, 2'd2, 1'b0, 32'h040, 32'hCAFE_F00D, 1'b0, '0, 32'hCAFE_F00D, 4'b1111);
        wait_done();
        repeat (3) step();
        check("rd_queue_empty", 32'(raq.size()), 32'd0);
        check("wr_queue_empty", 32'(wq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
